// File: rtl/vga_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_pkg : shared 640x480 geometry, tile grid and RGB332 layout    Rev 1.0
//------------------------------------------------------------------------------
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;
  localparam int TILE_LOG2 = 5;
  localparam int GRID_COLS = H_VISIBLE >> TILE_LOG2;
  localparam int GRID_ROWS = V_VISIBLE >> TILE_LOG2;
  localparam int COORD_W   = 11;

  localparam int RED_W = 3;
  localparam int GRN_W = 3;
  localparam int BLU_W = 2;
  localparam int RGB_W = RED_W + GRN_W + BLU_W;

  typedef struct packed {
    logic [RED_W-1:0] r;
    logic [GRN_W-1:0] g;
    logic [BLU_W-1:0] b;
  } rgb332_t;

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_sync_delay : DEPTH-stage shift line with configurable reset value  Rev 1.0
//------------------------------------------------------------------------------
module vga_sync_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] sr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= {DEPTH{RST_VAL}};
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_block_renderer.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_block_renderer : one 32x32 tile on a background, 2-cycle pipeline  Rev 1.0
//------------------------------------------------------------------------------
module vga_block_renderer
  import vga_pkg::*;
#(
  parameter logic [RGB_W-1:0] BG_COLOR     = 8'h00,
  parameter bit               BORDER_EN    = 1'b0,
  parameter logic [RGB_W-1:0] BORDER_COLOR = 8'hFF,
  parameter logic             SYNC_IDLE    = 1'b1
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic               blank,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [4:0]         xpos,
  input  logic [3:0]         ypos,
  input  logic [RGB_W-1:0]   rgb,
  output logic [RED_W-1:0]   red,
  output logic [GRN_W-1:0]   grn,
  output logic [BLU_W-1:0]   blu,
  output logic               hs_out,
  output logic               vs_out,
  output logic               frame_tick
);

  logic               capture_w;
  logic [4:0]         xs_q, xs_d;
  logic [3:0]         ys_q, ys_d;
  logic [RGB_W-1:0]   cs_q, cs_d;
  logic               capture_q;
  logic               tick_q;

  logic               hit_q, hit_d;
  logic               edge_q, edge_d;
  logic               blank_q;
  logic [RGB_W-1:0]   cs1_q;
  rgb332_t            color_q, color_d;

  // First line of vertical blanking: the whole visible frame has been drawn.
  assign capture_w = (vcount == COORD_W'(V_VISIBLE)) && (hcount == '0);

  always_comb begin
    xs_d = xs_q;
    ys_d = ys_q;
    cs_d = cs_q;
    if (capture_w) begin
      xs_d = xpos;
      ys_d = ypos;
      cs_d = rgb;
    end
  end

  always_comb begin
    hit_d  = !blank
             && (hcount[COORD_W-1:TILE_LOG2] == {1'b0, xs_q})
             && (vcount[COORD_W-1:TILE_LOG2] == {2'b00, ys_q});
    edge_d = (hcount[TILE_LOG2-1:0] == '0) || (hcount[TILE_LOG2-1:0] == '1)
          || (vcount[TILE_LOG2-1:0] == '0) || (vcount[TILE_LOG2-1:0] == '1);
  end

  always_comb begin
    color_d = rgb332_t'(BG_COLOR);
    if (blank_q) begin
      color_d = '0;
    end else if (hit_q && edge_q && BORDER_EN) begin
      color_d = rgb332_t'(BORDER_COLOR);
    end else if (hit_q) begin
      color_d = rgb332_t'(cs1_q);
    end
  end

  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      xs_q      <= '0;
      ys_q      <= '0;
      cs_q      <= '0;
      capture_q <= 1'b0;
      tick_q    <= 1'b0;
      hit_q     <= 1'b0;
      edge_q    <= 1'b0;
      blank_q   <= 1'b1;
      cs1_q     <= '0;
      color_q   <= '0;
    end else begin
      xs_q      <= xs_d;
      ys_q      <= ys_d;
      cs_q      <= cs_d;
      capture_q <= capture_w;
      tick_q    <= capture_q;
      hit_q     <= hit_d;
      edge_q    <= edge_d;
      blank_q   <= blank;
      cs1_q     <= cs_q;
      color_q   <= color_d;
    end
  end

  vga_sync_delay #(
    .WIDTH   (2),
    .DEPTH   (2),
    .RST_VAL ({SYNC_IDLE, SYNC_IDLE})
  ) u_sync_delay (
    .clk_i  (pixel_clk),
    .rst_ni (reset),
    .d_i    ({hs_in, vs_in}),
    .q_o    ({hs_out, vs_out})
  );

  assign red        = color_q.r;
  assign grn        = color_q.g;
  assign blu        = color_q.b;
  assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_block_renderer.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_vga_block_renderer : scoreboard bench for the tile renderer  Rev 1.0
//------------------------------------------------------------------------------
module tb_vga_block_renderer;

  localparam logic [7:0] BG_A   = 8'h25;
  localparam logic [7:0] BORD_B = 8'h1C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount = '0, vcount = '0;
  logic        blank = 1'b1, hs_in = 1'b1, vs_in = 1'b1;
  logic [4:0]  xpos = '0;
  logic [3:0]  ypos = '0;
  logic [7:0]  rgb = '0;

  logic [2:0] red_a, grn_a, red_b, grn_b;
  logic [1:0] blu_a, blu_b;
  logic       hs_a, vs_a, tick_a, hs_b, vs_b, tick_b;

  always #20 clk = ~clk;

  vga_block_renderer #(.BG_COLOR(BG_A), .BORDER_EN(1'b0), .BORDER_COLOR(8'hFF), .SYNC_IDLE(1'b1)) dut_a (
    .pixel_clk(clk), .reset(rst_n), .hcount(hcount), .vcount(vcount), .blank(blank),
    .hs_in(hs_in), .vs_in(vs_in), .xpos(xpos), .ypos(ypos), .rgb(rgb),
    .red(red_a), .grn(grn_a), .blu(blu_a), .hs_out(hs_a), .vs_out(vs_a), .frame_tick(tick_a));

  vga_block_renderer #(.BG_COLOR(8'h00), .BORDER_EN(1'b1), .BORDER_COLOR(BORD_B), .SYNC_IDLE(1'b1)) dut_b (
    .pixel_clk(clk), .reset(rst_n), .hcount(hcount), .vcount(vcount), .blank(blank),
    .hs_in(hs_in), .vs_in(vs_in), .xpos(xpos), .ypos(ypos), .rgb(rgb),
    .red(red_b), .grn(grn_b), .blu(blu_b), .hs_out(hs_b), .vs_out(vs_b), .frame_tick(tick_b));

  typedef struct {
    logic [7:0] ca;
    logic [7:0] cb;
    logic       hs;
    logic       vs;
    logic       tick;
  } exp_t;

  typedef struct {
    int         h;
    int         v;
    logic [7:0] ca;
  } vec_t;

  exp_t sbq[$];
  vec_t tab[10];
  int   n_cmp = 0, n_bad = 0;

  // Reference shadow: what the tile should be drawn from this frame.
  logic [4:0] mxs = '0;
  logic [3:0] mys = '0;
  logic [7:0] mcs = '0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (h=%0d v=%0d t=%0t)", name, act, req, hcount, vcount, $time);
    end
  endtask

  function automatic logic [7:0] model(input int h, input int v, input bit ben,
                                       input logic [7:0] bg, input logic [7:0] bord);
    int x0, y0;
    bit hit, edg;
    if (h >= 640 || v >= 480) return 8'h00;
    x0  = 32 * int'(mxs);
    y0  = 32 * int'(mys);
    hit = (h >= x0) && (h <= x0 + 31) && (v >= y0) && (v <= y0 + 31);
    edg = (h == x0) || (h == x0 + 31) || (v == y0) || (v == y0 + 31);
    if (hit && edg && ben) return bord;
    if (hit) return mcs;
    return bg;
  endfunction

  task automatic step(input int h, input int v, input bit use_tab = 1'b0, input logic [7:0] tab_exp = 8'h00);
    exp_t e, r;
    logic hsi, vsi;
    hsi = 1'($urandom_range(0, 1));
    vsi = 1'($urandom_range(0, 1));
    hcount = 11'(h);
    vcount = 11'(v);
    blank  = (h >= 640) || (v >= 480);
    hs_in  = hsi;
    vs_in  = vsi;
    e.ca   = use_tab ? tab_exp : model(h, v, 1'b0, BG_A, 8'hFF);
    e.cb   = model(h, v, 1'b1, 8'h00, BORD_B);
    e.hs   = hsi;
    e.vs   = vsi;
    e.tick = (h == 0) && (v == 480);
    if (e.tick) begin
      mxs = xpos;
      mys = ypos;
      mcs = rgb;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: queue empty, got nothing required an entry");
    end else begin
      r = sbq.pop_front();
      chk("color_a", {red_a, grn_a, blu_a}, r.ca);
      chk("color_b", {red_b, grn_b, blu_b}, r.cb);
      chk("hs_out",  {7'b0, hs_a}, {7'b0, r.hs});
      chk("vs_out",  {7'b0, vs_a}, {7'b0, r.vs});
      chk("hs_b",    {7'b0, hs_b}, {7'b0, r.hs});
      chk("tick",    {7'b0, tick_a}, {7'b0, r.tick});
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_color"}, {red_a, grn_a, blu_a}, 8'h00);
    chk({tag, "_color_b"}, {red_b, grn_b, blu_b}, 8'h00);
    chk({tag, "_hs"}, {7'b0, hs_a}, 8'h01);
    chk({tag, "_vs"}, {7'b0, vs_a}, 8'h01);
    chk({tag, "_tick"}, {7'b0, tick_a}, 8'h00);
  endtask

  // Release on a cycle boundary; the pipeline then still holds its reset contents.
  task automatic release_reset();
    exp_t rs;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mxs = '0;
    mys = '0;
    mcs = '0;
    rs.ca = 8'h00; rs.cb = 8'h00; rs.hs = 1'b1; rs.vs = 1'b1; rs.tick = 1'b0;
    sbq.delete();
    sbq.push_back(rs);
  endtask

  task automatic capture_frame();
    step(0, 480);
    step(1, 480);
    step(2, 480);
  endtask

  initial begin
    tab[0] = '{96, 64, 8'hE0};
    tab[1] = '{127, 95, 8'hE0};
    tab[2] = '{110, 80, 8'hE0};
    tab[3] = '{127, 64, 8'hE0};
    tab[4] = '{95, 64, BG_A};
    tab[5] = '{128, 64, BG_A};
    tab[6] = '{100, 63, BG_A};
    tab[7] = '{100, 96, BG_A};
    tab[8] = '{700, 80, 8'h00};
    tab[9] = '{100, 500, 8'h00};

    hcount = 11'd300;
    vcount = 11'd100;
    blank  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    release_reset();

    // Shadow starts as a black tile at (0,0).
    step(5, 5);
    step(0, 0);
    step(40, 5);

    // Tile placement at column 3, row 2.
    xpos = 5'd3; ypos = 4'd2; rgb = 8'hE0;
    capture_frame();
    for (int i = 0; i < 10; i++) begin
      step(tab[i].h, tab[i].v, 1'b1, tab[i].ca);
    end

    // Asynchronous reset in the middle of a visible line.
    for (int i = 0; i < 3; i++) step(300, 100);
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_state("midline");
    hcount = 11'd301;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("held");
    release_reset();
    step(300, 100);
    step(10, 10);
    xpos = 5'd5; ypos = 4'd3; rgb = 8'h1C;
    step(10, 11);
    capture_frame();
    for (int h = 156; h < 196; h += 3) step(h, 96);

    // Mid-frame input change must not show before the next capture.
    xpos = 5'd3; ypos = 4'd7; rgb = 8'h03;
    capture_frame();
    xpos = 5'd10;
    rgb  = 8'h55;
    for (int v = 200; v < 480; v += 7) begin
      step(96, v); step(127, v); step(128, v); step(320, v); step(340, v);
    end
    // Value present on the capture cycle itself is the one taken.
    rgb = 8'h92;
    capture_frame();
    for (int v = 220; v < 260; v += 3) begin
      step(96, v); step(127, v); step(320, v); step(351, v); step(352, v);
    end

    // Out-of-range column: the tile would sit entirely in horizontal blanking.
    xpos = 5'd25; ypos = 4'd14; rgb = 8'hFF;
    capture_frame();
    for (int v = 446; v < 484; v += 5) begin
      for (int h = 0; h < 800; h += 13) step(h, v);
    end

    // Border ring on the second instance.
    xpos = 5'd0; ypos = 4'd0; rgb = 8'h4A;
    capture_frame();
    step(0, 0); step(31, 5); step(5, 31); step(5, 5); step(31, 31); step(32, 5); step(5, 32);
    for (int i = 0; i < 40; i++) step($urandom_range(0, 799), $urandom_range(0, 524));
    step(0, 1);
    step(0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
